pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Owns the program counter and sequences instruction issue for the single-issue processor core. Each cycle it either loads the target from the combinational next-PC unit or holds the PC while a multi-cycle multiply/divide runs. It launches the multdiv unit, waits on its ready handshake with a timeout, and tells the datapath when register writeback and exception reporting are allowed.

## Interface
Parameters:
- IMEM_AW, 12, instruction memory address width; `address_imem` is `pc[IMEM_AW-1:0]`.
- MD_TIMEOUT, 40, maximum number of MD_WAIT cycles before forced abort. Legal range is 2..255.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `next_pc` in 32: target from the next-PC unit (branch/jump/jr/bex already resolved).
- `is_mul` in 1: the current instruction is a multiply.
- `is_div` in 1: the current instruction is a divide.
- `md_ready` in 1: multdiv result valid.
- `md_exception` in 1: multdiv error, qualified by `md_ready`.
- `pc` out 32: current PC register.
- `pc_plus_1` out 32: `pc + 1`, modulo 2^32.
- `address_imem` out IMEM_AW: instruction fetch address.
- `ctrl_MULT` out 1: one-cycle multiply start pulse.
- `ctrl_DIV` out 1: one-cycle divide start pulse.
- `stall` out 1: the PC is being held this cycle.
- `wb_enable` out 1: normal (non-multdiv) writeback permitted this cycle.
- `md_commit` out 1: write the multdiv result to rd this cycle.
- `md_exc` out 1: write rstatus for the multdiv error this cycle. Asserted only together with `md_commit`.

## Operation
- State register has two states: RUN and MD_WAIT. There is an 8-bit wait counter `wcnt`.
- Reset, asynchronous, applies immediately:
  - `pc` = 0, state = RUN, `wcnt` = 0.
  - While `reset` is high, every combinational output pulse is forced to 0: `ctrl_MULT`, `ctrl_DIV`, `stall`, `wb_enable`, `md_commit`, `md_exc`.
- RUN, with `is_mul` and `is_div` both 0:
  - `wb_enable` = 1, `stall` = 0.
  - On the clock edge, `pc` <= `next_pc`.
- RUN, with `is_mul` or `is_div` set (issue cycle):
  - `ctrl_MULT` = `is_mul`. `ctrl_DIV` = `is_div` & ~`is_mul`, so multiply wins if both are set.
  - `stall` = 1, `wb_enable` = 0.
  - `pc` holds. `wcnt` <= 0. Next state is MD_WAIT.
  - `md_ready` is ignored in the issue cycle.
- MD_WAIT:
  - `stall` = 1, `wb_enable` = 0, no start pulses. `is_mul` and `is_div` are ignored.
  - If `md_ready` = 1:
    - `md_commit` = 1 and `md_exc` = `md_exception`.
    - On the edge, `pc` <= `pc_plus_1` and state returns to RUN. `next_pc` is not used.
  - Else if `wcnt` == MD_TIMEOUT-1 (timeout):
    - `md_commit` = 1 and `md_exc` = 1.
    - `pc` <= `pc_plus_1`, state returns to RUN.
  - Else: `wcnt` <= `wcnt` + 1, `pc` holds.
  - If `md_ready` arrives in the same cycle as the timeout, `md_ready` wins and `md_exc` = `md_exception`.
- Arithmetic: `pc_plus_1` wraps, so 0xFFFFFFFF + 1 = 0. `address_imem` is a plain truncation of `pc`.
- Back-to-back multdiv instructions:
  - The RUN cycle following a commit is a fresh issue cycle.
  - There is no dead cycle beyond the issue cycle itself.

## Timing
- Non-multdiv instruction:
  - 1 cycle.
  - `pc` updates at the first rising edge after the instruction is presented.
- Multdiv instruction:
  - 1 issue cycle plus k MD_WAIT cycles, where k is the number of the MD_WAIT cycle in which `md_ready` is first seen high (1 ≤ k ≤ MD_TIMEOUT).
  - `pc` advances at the end of the commit cycle.
- All outputs other than `pc` and `address_imem` are combinational from the state, `wcnt` and the inputs.
  - The datapath samples `md_commit` and `wb_enable` on the same edge that updates `pc`.
- Reset mid-MD_WAIT:
  - Return to RUN with `pc` = 0 immediately.
  - A late `md_ready` after reset is ignored unless an issue cycle has occurred since.

## Test plan
- Reset, then run 3 cycles of non-multdiv instructions with `next_pc` = 5, 9, 2:
  - required: `pc` = 0 → 5 → 9 → 2, `wb_enable` = 1 throughout, `stall` = 0 throughout.
- At `pc` = 4, set `is_mul` = 1 and raise `md_ready` in the 3rd MD_WAIT cycle:
  - required: `ctrl_MULT` high for exactly 1 cycle and `stall` high for 4 cycles.
  - required: `md_commit` = 1 only in the commit cycle, `md_exc` = 0, then `pc` = 5.
- `is_div` = 1 and `is_mul` = 1 together; 2 cycles later set `md_ready` = 1 with `md_exception` = 1:
  - required: `ctrl_MULT` = 1 and `ctrl_DIV` = 0.
  - required: `md_commit` = 1 and `md_exc` = 1, then `pc` advances by 1.
- Divide with `md_ready` never asserted, MD_TIMEOUT = 40:
  - required: commit with `md_exc` = 1 on the 40th MD_WAIT cycle, 41 stall cycles total, then `pc` advances by 1.
- Assert `reset` in MD_WAIT at `pc` = 0x20, then pulse `md_ready` after release:
  - required: `pc` = 0 immediately, state = RUN, no `md_commit`.
- `pc` = 0xFFFFFFFF with a multiply that completes:
  - required: `pc` = 0 after commit, `address_imem` = 0x000.

Source files
------------

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module  : pc_sequencer
// Purpose : Program counter and instruction-issue sequencer with multdiv wait.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int IMEM_AW    = 12,
  parameter int MD_TIMEOUT = 40
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        next_pc,
  input  logic               is_mul,
  input  logic               is_div,
  input  logic               md_ready,
  input  logic               md_exception,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus_1,
  output logic [IMEM_AW-1:0] address_imem,
  output logic               ctrl_MULT,
  output logic               ctrl_DIV,
  output logic               stall,
  output logic               wb_enable,
  output logic               md_commit,
  output logic               md_exc
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MD_TIMEOUT - 1);

  state_t      state, state_next;
  logic [7:0]  wcnt, wcnt_next;
  logic [31:0] pc_next;

  assign pc_plus_1    = pc + 32'd1;
  assign address_imem = pc[IMEM_AW-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      wcnt  <= 8'd0;
      pc    <= 32'd0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    pc_next    = pc;
    ctrl_MULT  = 1'b0;
    ctrl_DIV   = 1'b0;
    stall      = 1'b0;
    wb_enable  = 1'b0;
    md_commit  = 1'b0;
    md_exc     = 1'b0;

    case (state)
      RUN: begin
        if (is_mul || is_div) begin
          // Multiply takes priority when both decode bits are set.
          ctrl_MULT  = is_mul;
          ctrl_DIV   = is_div & ~is_mul;
          stall      = 1'b1;
          wcnt_next  = 8'd0;
          state_next = MD_WAIT;
        end else begin
          wb_enable = 1'b1;
          pc_next   = next_pc;
        end
      end
      MD_WAIT: begin
        stall = 1'b1;
        if (md_ready) begin
          md_commit  = 1'b1;
          md_exc     = md_exception;
          pc_next    = pc_plus_1;
          state_next = RUN;
        end else if (wcnt == TIMEOUT_LAST) begin
          // Unit never answered: commit an error so the core can move on.
          md_commit  = 1'b1;
          md_exc     = 1'b1;
          pc_next    = pc_plus_1;
          state_next = RUN;
        end else begin
          wcnt_next = wcnt + 8'd1;
        end
      end
      default: state_next = RUN;
    endcase

    if (reset) begin
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      stall     = 1'b0;
      wb_enable = 1'b0;
      md_commit = 1'b0;
      md_exc    = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module  : tb_pc_sequencer
// Purpose : Directed scoreboard bench for pc_sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic [31:0] next_pc;
  logic        is_mul, is_div, md_ready, md_exception;
  logic [31:0] pc, pc_plus_1;
  logic [11:0] address_imem;
  logic        ctrl_MULT, ctrl_DIV, stall, wb_enable, md_commit, md_exc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        mult;
    logic        div;
    logic        stl;
    logic        wb;
    logic        commit;
    logic        exc;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  pc_sequencer #(.IMEM_AW(12), .MD_TIMEOUT(40)) dut (
    .clock        (clock),
    .reset        (reset),
    .next_pc      (next_pc),
    .is_mul       (is_mul),
    .is_div       (is_div),
    .md_ready     (md_ready),
    .md_exception (md_exception),
    .pc           (pc),
    .pc_plus_1    (pc_plus_1),
    .address_imem (address_imem),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .stall        (stall),
    .wb_enable    (wb_enable),
    .md_commit    (md_commit),
    .md_exc       (md_exc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic m, input logic d, input logic s, input logic w,
                              input logic c, input logic x, input logic [31:0] p);
    exp_t e;
    e.mult = m; e.div = d; e.stl = s; e.wb = w; e.commit = c; e.exc = x; e.pc = p;
    return e;
  endfunction

  // Called just after a rising edge: drive inputs, queue the expected response,
  // compare at the falling edge, then advance through the next rising edge.
  task automatic drive(input string tag, input logic [31:0] np, input logic m, input logic d,
                       input logic rdy, input logic mx, input exp_t e);
    exp_t got;
    logic [31:0] pc_exp_plus;
    next_pc = np; is_mul = m; is_div = d; md_ready = rdy; md_exception = mx;
    sb.push_back(e);
    @(negedge clock);
    got = sb.pop_front();
    pc_exp_plus = got.pc + 32'd1;
    chk({tag, ".pc"},        pc,               got.pc);
    chk({tag, ".pc_plus_1"}, pc_plus_1,        pc_exp_plus);
    chk({tag, ".addr"},      32'(address_imem), 32'(got.pc[11:0]));
    chk({tag, ".ctrl_MULT"}, 32'(ctrl_MULT),   32'(got.mult));
    chk({tag, ".ctrl_DIV"},  32'(ctrl_DIV),    32'(got.div));
    chk({tag, ".stall"},     32'(stall),       32'(got.stl));
    chk({tag, ".wb_enable"}, 32'(wb_enable),   32'(got.wb));
    chk({tag, ".md_commit"}, 32'(md_commit),   32'(got.commit));
    chk({tag, ".md_exc"},    32'(md_exc),      32'(got.exc));
    @(posedge clock);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".ctrl_MULT"}, 32'(ctrl_MULT), 32'd0);
    chk({tag, ".ctrl_DIV"},  32'(ctrl_DIV),  32'd0);
    chk({tag, ".stall"},     32'(stall),     32'd0);
    chk({tag, ".wb_enable"}, 32'(wb_enable), 32'd0);
    chk({tag, ".md_commit"}, 32'(md_commit), 32'd0);
    chk({tag, ".md_exc"},    32'(md_exc),    32'd0);
  endtask

  initial begin
    // Reset with a multiply and md_ready presented: all pulses must stay low.
    reset = 1'b1; next_pc = 32'h7; is_mul = 1'b1; is_div = 1'b0;
    md_ready = 1'b1; md_exception = 1'b1;
    @(negedge clock);
    chk("rst.pc", pc, 32'd0);
    chk_quiet("rst");
    @(posedge clock);
    #1;
    chk("rst_edge.pc", pc, 32'd0);
    reset = 1'b0;

    // Plain sequencing 0 -> 5 -> 9 -> 2 -> 4
    drive("seq0", 32'd5, 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 32'd0));
    drive("seq1", 32'd9, 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 32'd5));
    drive("seq2", 32'd2, 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 32'd9));
    drive("seq3", 32'd4, 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 32'd2));

    // Multiply at pc=4, ready in 3rd wait cycle; is_mul left high in wait (ignored)
    drive("mul_iss", 32'd100, 1, 0, 1, 0, mk(1, 0, 1, 0, 0, 0, 32'd4));
    drive("mul_w1",  32'd100, 1, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 32'd4));
    drive("mul_w2",  32'd100, 1, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 32'd4));
    drive("mul_w3",  32'd100, 1, 0, 1, 0, mk(0, 0, 1, 0, 1, 0, 32'd4));

    // Both set: multiply wins; ready with exception on 2nd wait cycle
    drive("both_iss", 32'd50, 1, 1, 0, 0, mk(1, 0, 1, 0, 0, 0, 32'd5));
    drive("both_w1",  32'd50, 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 32'd5));
    drive("both_w2",  32'd50, 0, 0, 1, 1, mk(0, 0, 1, 0, 1, 1, 32'd5));

    // Divide that never completes: forced error commit on 40th wait cycle
    drive("to_iss", 32'd50, 0, 1, 0, 0, mk(0, 1, 1, 0, 0, 0, 32'd6));
    for (int k = 1; k < 40; k++)
      drive("to_wait", 32'd50, 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 32'd6));
    drive("to_w40", 32'd50, 0, 0, 0, 0, mk(0, 0, 1, 0, 1, 1, 32'd6));

    // Ready exactly at the timeout cycle: ready wins, md_exc follows md_exception
    drive("rt_iss", 32'd50, 0, 1, 0, 0, mk(0, 1, 1, 0, 0, 0, 32'd7));
    for (int k = 1; k < 40; k++)
      drive("rt_wait", 32'd50, 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 32'd7));
    drive("rt_w40", 32'd50, 0, 0, 1, 0, mk(0, 0, 1, 0, 1, 0, 32'd7));

    // Reset while waiting at pc=0x20
    drive("r_seq", 32'h20, 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 32'd8));
    drive("r_iss", 32'h99, 1, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 32'h20));
    drive("r_w1",  32'h99, 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 32'h20));
    reset = 1'b1;
    #1;
    chk("r_async.pc", pc, 32'd0);
    chk_quiet("r_async");
    @(negedge clock);
    #1;
    next_pc = 32'd0; is_mul = 1'b0; md_ready = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("r_rel.pc", pc, 32'd0);
    drive("r_late", 32'd3, 0, 0, 1, 1, mk(0, 0, 0, 1, 0, 0, 32'd0));

    // Wraparound through a multiply commit at 0xFFFFFFFF
    drive("w_seq", 32'hFFFF_FFFF, 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 32'd3));
    drive("w_iss", 32'd77, 1, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 32'hFFFF_FFFF));
    drive("w_w1",  32'd77, 0, 0, 1, 0, mk(0, 0, 1, 0, 1, 0, 32'hFFFF_FFFF));
    drive("w_after", 32'd1, 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 32'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
